// File: rtl/ctrl_seq_bh_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, one-hot
// ring states and the packed control word.
package sap1_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef struct packed {
        logic CP;
        logic EP;
        logic LM;
        logic CE;
        logic LI;
        logic EI;
        logic LA;
        logic EA;
        logic SU;
        logic EU;
        logic LB;
        logic LO;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_seq_bh_ring_counter.sv
// Six-state one-hot ring counter for the SAP-1 timing states.
//
// state | meaning
// T1    | address state: PC onto bus, MAR load
// T2    | increment state: PC advances
// T3    | memory state: RAM word into IR
// T4    | first execute state
// T5    | second execute state
// T6    | third execute state, then back to T1
//
// HOLD freezes the ring; WRAP forces T1 at the next edge (HOLD wins).
module ring_counter_bh
    import sap1_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       HOLD,
    input  logic       WRAP,
    output logic [5:0] T
);

    t_state_e r_state;
    t_state_e w_next;

    // State register, asynchronously cleared to T1.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= T1;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: hold, early wrap, or rotate one position.
    always_comb begin
        w_next = r_state;
        if (!HOLD) begin
            if (WRAP) begin
                w_next = T1;
            end else begin
                case (r_state)
                    T1:      w_next = T2;
                    T2:      w_next = T3;
                    T3:      w_next = T4;
                    T4:      w_next = T5;
                    T5:      w_next = T6;
                    default: w_next = T1;
                endcase
            end
        end
    end

    assign T = r_state;

endmodule

// File: rtl/ctrl_seq_bh.sv
// SAP-1 controller-sequencer: ring counter plus control-word decoder and
// halted flag. Build option CTRL_SEQ_VARCYC_EN shortens the machine cycle
// so each instruction returns to T1 right after its last active state.
module ctrl_seq_bh
    import sap1_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] OP,
    output logic [5:0] T,
    output logic       CP,
    output logic       EP,
    output logic       LM,
    output logic       CE,
    output logic       LI,
    output logic       EI,
    output logic       LA,
    output logic       EA,
    output logic       SU,
    output logic       EU,
    output logic       LB,
    output logic       LO,
    output logic       HLT
);

    logic [5:0] w_t;
    logic       r_halted;
    logic       w_hlt_t4;
    logic       w_hold;
    logic       w_wrap;
    ctrl_word_t w_cw;

    ring_counter_bh u_ring (
        .CLK  (CLK),
        .CLR  (CLR),
        .HOLD (w_hold),
        .WRAP (w_wrap),
        .T    (w_t)
    );

    // HLT decoded in T4 freezes the ring at the same edge that sets the flag.
    assign w_hlt_t4 = (w_t == T4) && (OP == OP_HLT);
    assign w_hold   = r_halted | w_hlt_t4;

`ifdef CTRL_SEQ_VARCYC_EN
    // OUT and unknown opcodes finish in T4, LDA in T5; ADD/SUB run to T6.
    assign w_wrap = ((w_t == T4) && (OP != OP_LDA) && (OP != OP_ADD) &&
                     (OP != OP_SUB) && (OP != OP_HLT)) ||
                    ((w_t == T5) && (OP == OP_LDA));
`else
    assign w_wrap = 1'b0;
`endif

    // Halted flag: set by HLT in T4, cleared only by CLR.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_halted <= 1'b0;
        end else if (w_hlt_t4) begin
            r_halted <= 1'b1;
        end
    end

    // Control-word decode from ring state and opcode; zero in reset or halt.
    always_comb begin
        w_cw = '0;
        if (!CLR && !r_halted) begin
            case (w_t)
                T1: begin
                    w_cw.EP = 1'b1;
                    w_cw.LM = 1'b1;
                end
                T2: w_cw.CP = 1'b1;
                T3: begin
                    w_cw.CE = 1'b1;
                    w_cw.LI = 1'b1;
                end
                T4: begin
                    if (OP == OP_LDA || OP == OP_ADD || OP == OP_SUB) begin
                        w_cw.EI = 1'b1;
                        w_cw.LM = 1'b1;
                    end else if (OP == OP_OUT) begin
                        w_cw.EA = 1'b1;
                        w_cw.LO = 1'b1;
                    end
                end
                T5: begin
                    if (OP == OP_LDA) begin
                        w_cw.CE = 1'b1;
                        w_cw.LA = 1'b1;
                    end else if (OP == OP_ADD || OP == OP_SUB) begin
                        w_cw.CE = 1'b1;
                        w_cw.LB = 1'b1;
                    end
                end
                T6: begin
                    if (OP == OP_ADD || OP == OP_SUB) begin
                        w_cw.EU = 1'b1;
                        w_cw.LA = 1'b1;
                        w_cw.SU = (OP == OP_SUB);
                    end
                end
                default: w_cw = '0;
            endcase
        end
    end

    assign T   = w_t;
    assign CP  = w_cw.CP;
    assign EP  = w_cw.EP;
    assign LM  = w_cw.LM;
    assign CE  = w_cw.CE;
    assign LI  = w_cw.LI;
    assign EI  = w_cw.EI;
    assign LA  = w_cw.LA;
    assign EA  = w_cw.EA;
    assign SU  = w_cw.SU;
    assign EU  = w_cw.EU;
    assign LB  = w_cw.LB;
    assign LO  = w_cw.LO;
    assign HLT = ~CLR & (r_halted | w_hlt_t4);

endmodule

// File: tb/tb_ctrl_seq_bh.sv
// Self-checking bench for ctrl_seq_bh: a step/halted model compared every
// cycle, plus literal checks on cycle lengths, halt and async clear.
module tb_ctrl_seq_bh;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [3:0] OP  = 4'b0000;
    logic [5:0] T;
    logic       CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT;

    ctrl_seq_bh dut (
        .CLK(CLK), .CLR(CLR), .OP(OP), .T(T),
        .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI),
        .LA(LA), .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO), .HLT(HLT)
    );

    always #5 CLK = ~CLK;

    // Word bit masks, ordered {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}.
    localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                            M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                            M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                            M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_step   = 0;
    bit          m_halted = 1'b0;
    logic [11:0] w_seen [6];

    function automatic logic [11:0] dut_word();
        return {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Clocks per instruction for the build in use.
    function automatic int cyc_len(input logic [3:0] op);
`ifdef CTRL_SEQ_VARCYC_EN
        if (op == 4'b0000) return 5;
        if (op == 4'b0001 || op == 4'b0010) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    // Micro-program table: which signals each instruction uses in each step.
    function automatic logic [11:0] word_of(input int step, input logic [3:0] op);
        bit lda, arith;
        lda   = (op == 4'b0000);
        arith = (op == 4'b0001) || (op == 4'b0010);
        case (step)
            0: return M_EP | M_LM;
            1: return M_CP;
            2: return M_CE | M_LI;
            3: return (lda || arith) ? (M_EI | M_LM) :
                      (op == 4'b1110) ? (M_EA | M_LO) : 12'h000;
            4: return lda ? (M_CE | M_LA) : arith ? (M_CE | M_LB) : 12'h000;
            5: return arith ? (M_EU | M_LA | ((op == 4'b0010) ? M_SU : 12'h000)) : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // Model: step index within the instruction plus the halted flag.
    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 3 && OP == 4'b1111) m_halted = 1'b1;
            else if (m_step + 1 >= cyc_len(OP)) m_step = 0;
            else m_step = m_step + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        logic [5:0]  e_t;
        logic [11:0] e_w;
        logic        e_h;
        e_t = CLR ? 6'b000001 : 6'(1 << m_step);
        e_w = (CLR || m_halted) ? 12'h000 : word_of(m_step, OP);
        e_h = !CLR && (m_halted || (m_step == 3 && OP == 4'b1111));
        chk("cyc_T", 32'(T), 32'(e_t));
        chk("cyc_word", 32'(dut_word()), 32'(e_w));
        chk("cyc_HLT", 32'(HLT), 32'(e_h));
    end

    function automatic int t_index(input logic [5:0] t);
        for (int i = 0; i < 6; i++) if (t == 6'(1 << i)) return i;
        return -1;
    endfunction

    // Run one instruction from T1; record words per state; check length.
    task automatic run_instr(input logic [3:0] op, input int exp_len, input string name);
        int n;
        int idx;
        OP = op;
        n  = 0;
        for (int i = 0; i < 6; i++) w_seen[i] = 12'hFFF;
        do begin
            idx = t_index(T);
            if (idx >= 0) w_seen[idx] = dut_word();
            @(posedge CLK); #1;
            n++;
        end while (T != 6'b000001 && n < 12);
        chk({name, "_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic wait_t(input logic [5:0] target, input string name);
        int n;
        n = 0;
        while (T != target && n < 8) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({name, "_reach"}, 32'(T), 32'(target));
    endtask

    initial begin
        int l_lda, l_out, l_nop;
`ifdef CTRL_SEQ_VARCYC_EN
        l_lda = 5; l_out = 4; l_nop = 4;
`else
        l_lda = 6; l_out = 6; l_nop = 6;
`endif
        CLR = 1'b1;
        OP  = 4'b0000;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_T", 32'(T), 32'h01);
        chk("rst_word", 32'(dut_word()), 32'h000);
        chk("rst_HLT", 32'(HLT), 32'h0);
        CLR = 1'b0;
        #1;
        chk("t1_word", 32'(dut_word()), 32'h600);

        run_instr(4'b0000, l_lda, "lda");
        chk("lda_t2", 32'(w_seen[1]), 32'h800);
        chk("lda_t3", 32'(w_seen[2]), 32'h180);
        chk("lda_t4", 32'(w_seen[3]), 32'h240);
        chk("lda_t5", 32'(w_seen[4]), 32'h120);

        run_instr(4'b1110, l_out, "out");
        chk("out_t4", 32'(w_seen[3]), 32'h011);

        run_instr(4'b0001, 6, "add");
        chk("add_t5", 32'(w_seen[4]), 32'h102);
        chk("add_t6", 32'(w_seen[5]), 32'h024);

        run_instr(4'b0010, 6, "sub");
        chk("sub_t5", 32'(w_seen[4]), 32'h102);
        chk("sub_t6", 32'(w_seen[5]), 32'h02C);

        run_instr(4'b0101, l_nop, "nop");
        chk("nop_t4", 32'(w_seen[3]), 32'h000);

        // Halt, then confirm it sticks across an opcode change.
        OP = 4'b1111;
        wait_t(6'b001000, "hlt_t4");
        chk("hlt_comb", 32'(HLT), 32'h1);
        repeat (5) @(posedge CLK);
        #1;
        OP = 4'b0000;
        repeat (6) @(posedge CLK);
        #1;
        chk("hlt_T", 32'(T), 32'h08);
        chk("hlt_flag", 32'(HLT), 32'h1);
        chk("hlt_word", 32'(dut_word()), 32'h000);

        // Sub-clock CLR pulse fully resets.
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
        #1;
        chk("pulse_T", 32'(T), 32'h01);
        chk("pulse_HLT", 32'(HLT), 32'h0);
        run_instr(4'b0000, l_lda, "lda2");

        // Asynchronous CLR mid-T5 of ADD.
        OP = 4'b0001;
        wait_t(6'b010000, "add_t5");
        CLR = 1'b1;
        #1;
        chk("aclr_T", 32'(T), 32'h01);
        chk("aclr_word", 32'(dut_word()), 32'h000);
        #1;
        CLR = 1'b0;
        run_instr(4'b0010, 6, "resume");
        chk("resume_t6", 32'(w_seen[5]), 32'h02C);

        repeat (2) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_seq_bh.md
# ctrl_seq_bh

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) with a control-word decoder that drives the load/enable pins of the program counter, MAR, RAM, instruction register, accumulator, B register, adder/subtracter and output register. Every buffer register in the datapath is sequenced from this block's LOAD-style outputs. Supports LDA, ADD, SUB, OUT and HLT; all other opcodes execute as NOP.

## Interface
Parameters:
- none; opcode and state encodings are fixed constants in the package.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- OP   input  4  opcode from instruction register upper nibble; valid T4–T6.
- T    output 6  one-hot state, T[0]=T1 … T[5]=T6.
- CP   output 1  program counter increment.
- EP   output 1  program counter drives bus.
- LM   output 1  MAR load.
- CE   output 1  RAM drives bus.
- LI   output 1  instruction register load.
- EI   output 1  IR address field drives bus.
- LA   output 1  accumulator load.
- EA   output 1  accumulator drives bus.
- SU   output 1  subtract select.
- EU   output 1  adder/subtracter drives bus.
- LB   output 1  B register load.
- LO   output 1  output register load.
- HLT  output 1  halt indication.

## Operation
- All control outputs active-high; any active-low conversion is done at the datapath.
- Control word is combinational from T, OP and the halted flag; forced all-zero while CLR is high or when halted.
- Fetch, opcode-independent: T1 EP,LM; T2 CP; T3 CE,LI.
- LDA 0000: T4 EI,LM; T5 CE,LA; T6 none.
- ADD 0001: T4 EI,LM; T5 CE,LB; T6 EU,LA.
- SUB 0010: as ADD, plus SU in T6.
- OUT 1110: T4 EA,LO; T5, T6 none.
- HLT 1111: in T4, HLT asserts combinationally; at the next rising edge the halted flag sets and T holds at T4. With the flag set: HLT=1, control word zero, OP ignored. Only CLR clears the flag.
- Any other opcode: no signals asserted in T4–T6.
- State advances T1→T2→…→T6→T1, one step per rising edge, unless halted.

## Timing
- Reset values: T=6'b000001, HLT=0, halted flag=0. All control outputs are 0 while CLR is high.
- The first rising edge after CLR falls leaves T1. The T1 word is visible from CLR release until that edge.
- The control word is stable for the whole state. The datapath samples it at the rising edge that ends the state.
- OP is sampled only during T4–T6. IR updates at the T3→T4 edge.
- A fixed cycle is 6 clocks per instruction.
- CLR mid-instruction (any Tn, any OP) returns T to T1 immediately. No partial-cycle completion.
- A CLR pulse shorter than one clock still fully resets.

## Configuration
- CTRL_SEQ_VARCYC_EN defined: variable machine cycle. After the last active state, the next state is T1 instead of continuing.
  - OUT and NOP return to T1 after T4.
  - LDA returns to T1 after T5.
  - ADD/SUB still use T6.
  - HLT is unchanged.
- Not defined: every instruction takes all six states.

## Structure
- Package `sap1_ctrl_pkg` holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - one-hot state constants T1–T6;
  - packed struct `ctrl_word_t` with fields CP..LO.
- Sub-module `ring_counter_bh`: 6-bit one-hot ring, async CLR to T1, with inputs HOLD (freeze) and WRAP (force T1 next edge).
- The top module holds the decoder and the halted flag, and drives HOLD and WRAP.

## Test plan
- CLR pulse, then OP=0000 → T sequence 1,2,4,8,16,32,1. Words per state: {EP,LM},{CP},{CE,LI},{EI,LM},{CE,LA},{}.
- OP=0001, then OP=0010 → T6 word is {EU,LA} for ADD and {EU,LA,SU} for SUB. T5 word is {CE,LB} for both.
- OP=1110 → T4 word {EA,LO}, T5/T6 all-zero. OP=0101 → T4–T6 all-zero.
- OP=1111 → HLT=1 in T4. T stays 6'b001000 for 10+ clocks with control word zero, including after OP changes to 0000. A CLR pulse then gives T=000001, HLT=0.
- CLR asserted asynchronously mid-T5 of ADD → T=000001 and all controls 0 within the same cycle. Normal fetch resumes after release.
- With CTRL_SEQ_VARCYC_EN defined, LDA, OUT, ADD in sequence → cycle lengths 5, 4, 6 clocks. Each return to T1 is visible in T.
